pipe_stage_skid: RTL
====================

Name: pipe_stage_skid

Overview:
- Parametrised successor to the fixed stall-only stage registers between pipeline stages (e.g. MEM->WB).
- Carries an arbitrary-width payload through STAGES register slices using valid/ready handshakes.
- Each slice has a skid buffer, so every ready signal is registered and there is no combinational ready path across the chain.
- Adds flush (bubble injection), a global stall freeze, and an occupancy count.

Parameters:
- DATA_W, 101, payload width in bits; the default is the writeback bundle {addr 32, alu_result 32, rdata 32, waddr 5}.
- STAGES, 1, number of cascaded slices; legal range 1..8.
- CNT_W, $clog2(2*STAGES+1), width of the occupancy count.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  freezes all state for the cycle.
- flush  in  1  discards all in-flight entries.
- in_valid  in  1  upstream has a payload.
- in_ready  out  1  pipeline accepts the payload this cycle.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  payload available downstream.
- out_ready  in  1  downstream accepts the payload.
- out_data  out  DATA_W  downstream payload.
- count  out  CNT_W  number of valid entries held (main + skid, all slices).

Behaviour:
- Slice state: main {data, valid} and skid {data, valid}. The slice output is main.
- Slice ready: in_ready of a slice = !skid.valid. This is a registered value only.
- Transfers per slice per cycle:
  - pop = main.valid & ready_dn.
  - push = valid_up & !skid.valid.
- Slice update rules:
  - pop & skid.valid -> main <= skid; skid.valid <= 0.
  - Otherwise, push & (!main.valid | pop) -> main <= input.
  - push & main.valid & !pop -> skid <= input; main holds.
  - main.valid clears only on pop with no refill.
- Chaining: slice k output feeds slice k+1. Top in_ready comes from slice 0; out_valid, out_data and out_ready connect to slice STAGES-1.
- Latency and throughput:
  - Latency is exactly STAGES cycles from accepted input to out_valid with an empty pipe.
  - Sustained throughput is 1 payload per cycle while out_ready = 1.
- Priority, highest first: rst > flush > stall > normal operation.
- rst:
  - All valid bits and all data registers are set to 0.
  - out_valid = 0, out_data = 0, count = 0, in_ready = 1 in the following cycle.
  - Reset asserted mid-burst discards everything; no partial transfer completes in that cycle.
- flush:
  - All valid bits are cleared next cycle; data registers hold their values.
  - in_ready is forced to 0 and out_valid is masked to 0 during the flush cycle, so no handshake completes.
  - count = 0 the next cycle.
- stall:
  - in_ready and out_valid are masked to 0; all registers hold; count holds.
  - out_data still shows main.data, which is don't-care for the consumer.
- count:
  - A registered sum of all valid bits, updated with the state.
  - Range 0..2*STAGES. It never wraps and never exceeds 2*STAGES.
- Full condition: every main and skid valid -> in_ready = 0. An in_valid held high is not lost; it waits.
- Empty condition: out_valid = 0 and out_data holds the last value.
- in_valid & in_ready in a cycle with simultaneous pop: both happen; count is unchanged.
- Ordering: strict FIFO order is preserved and no payload is duplicated or dropped except by flush or rst.

Decomposition:
- Package pipe_pkg:
  - wb_payload_t packed struct {addr, alu_result, rdata, waddr}.
  - WB_PAYLOAD_W constant = $bits(wb_payload_t).
  - MAX_STAGES = 8.
- Sub-module pipe_slice (DATA_W):
  - One main+skid slice with ports clk, rst, stall, flush, up_valid, up_ready, up_data, dn_valid, dn_ready, dn_data, occ[1:0].
  - The top level instantiates STAGES copies in a generate loop and sums occ into count.

Test Plan:
- STAGES=1, out_ready=1, stream in_data 0x1, 0x2, 0x3 on consecutive cycles -> out_data 0x1, 0x2, 0x3 on cycles 1, 2, 3; count stays 1; in_ready stays 1.
- STAGES=3, out_ready=0, push 6 words 0xA0..0xA5 -> after 6 accepts count=6 and in_ready=0; raise out_ready -> 0xA0..0xA5 emerge in order, count falls to 0.
- STAGES=2, pipe holding 3 entries, assert flush one cycle with in_valid=1, in_data=0xFF -> next cycle count=0 and out_valid=0; 0xFF never appears at the output.
- STAGES=2, streaming at full rate, assert stall for 4 cycles -> no handshake on either side during the stall, count constant; resumes with no loss or duplicate.
- Mid-burst rst with 4 entries held -> next cycle out_valid=0, out_data=0, count=0, in_ready=1; first post-reset word 0x55 arrives after exactly STAGES cycles.
- STAGES=4, randomised in_valid/out_ready at 50% for 10k cycles against a scoreboard model -> identical ordered output, and count always equals model occupancy within 0..8.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and limits for the skid-buffered pipeline stage.
package pipe_pkg;

    // Writeback bundle that travels MEM->WB by default.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] alu_result;
        logic [31:0] rdata;
        logic [4:0]  waddr;
    } wb_payload_t;

    localparam int WB_PAYLOAD_W = $bits(wb_payload_t);
    localparam int MAX_STAGES   = 8;

endpackage

// File: rtl/pipe_slice.sv
// One register slice with a skid entry. The upstream ready is taken only
// from the registered skid-valid bit, so no combinational ready path runs
// through the slice.
module pipe_slice #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              up_valid,
    output logic              up_ready,
    input  logic [DATA_W-1:0] up_data,
    output logic              dn_valid,
    input  logic              dn_ready,
    output logic [DATA_W-1:0] dn_data,
    output logic [1:0]        occ
);

    logic [DATA_W-1:0] main_data_reg, main_data_next;
    logic              main_valid_reg, main_valid_next;
    logic [DATA_W-1:0] skid_data_reg, skid_data_next;
    logic              skid_valid_reg, skid_valid_next;
    logic              hold;
    logic              pop;
    logic              push;

    // Both handshakes are masked while frozen or flushing, so push/pop are
    // already zero in those cycles.
    assign hold     = stall | flush;
    assign up_ready = ~skid_valid_reg & ~hold;
    assign dn_valid = main_valid_reg & ~hold;
    assign dn_data  = main_data_reg;
    assign pop      = dn_valid & dn_ready;
    assign push     = up_valid & up_ready;
    assign occ      = {1'b0, main_valid_reg} + {1'b0, skid_valid_reg};

    // Next-state: skid refills main first; otherwise input lands in main if
    // it is free (or draining), else parks in the skid entry.
    always_comb begin
        main_data_next  = main_data_reg;
        main_valid_next = main_valid_reg;
        skid_data_next  = skid_data_reg;
        skid_valid_next = skid_valid_reg;
        if (flush) begin
            main_valid_next = 1'b0;
            skid_valid_next = 1'b0;
        end else if (pop && skid_valid_reg) begin
            main_data_next  = skid_data_reg;
            skid_valid_next = 1'b0;
        end else if (push && (!main_valid_reg || pop)) begin
            main_data_next  = up_data;
            main_valid_next = 1'b1;
        end else if (push) begin
            skid_data_next  = up_data;
            skid_valid_next = 1'b1;
        end else if (pop) begin
            main_valid_next = 1'b0;
        end
    end

    // State registers; reset clears data as well as valid bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_data_reg  <= '0;
            main_valid_reg <= 1'b0;
            skid_data_reg  <= '0;
            skid_valid_reg <= 1'b0;
        end else begin
            main_data_reg  <= main_data_next;
            main_valid_reg <= main_valid_next;
            skid_data_reg  <= skid_data_next;
            skid_valid_reg <= skid_valid_next;
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Chain of STAGES skid slices carrying a payload with valid/ready, plus
// flush, global stall and an occupancy count.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W = WB_PAYLOAD_W,
    parameter int STAGES = 1,
    parameter int CNT_W  = $clog2(2*STAGES+1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  count
);

    logic [STAGES:0]   valid_c;
    logic [STAGES:0]   ready_c;
    logic [DATA_W-1:0] data_c [STAGES+1];
    logic [1:0]        occ_c  [STAGES];
    logic [CNT_W-1:0]  count_next;

    assign valid_c[0]      = in_valid;
    assign data_c[0]       = in_data;
    assign in_ready        = ready_c[0];
    assign out_valid       = valid_c[STAGES];
    assign out_data        = data_c[STAGES];
    assign ready_c[STAGES] = out_ready;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_slice
            pipe_slice #(.DATA_W(DATA_W)) u_slice (
                .clk      (clk),
                .rst      (rst),
                .stall    (stall),
                .flush    (flush),
                .up_valid (valid_c[gi]),
                .up_ready (ready_c[gi]),
                .up_data  (data_c[gi]),
                .dn_valid (valid_c[gi+1]),
                .dn_ready (ready_c[gi+1]),
                .dn_data  (data_c[gi+1]),
                .occ      (occ_c[gi])
            );
        end
    endgenerate

    // Occupancy is the sum of registered valid bits, so it moves with the state.
    always_comb begin
        count_next = '0;
        for (int i = 0; i < STAGES; i++) begin
            count_next = count_next + CNT_W'(occ_c[i]);
        end
    end

    assign count = count_next;

endmodule
